// File: rtl/pipe_ctrl.sv
// Pipeline controller: boot/run/memory-wait/error FSM, stage enables, bubble clears and valid tracking.
// Define PIPE_CTRL_PERF_EN to add saturating cycle/stall/flush performance counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       HDU_STALL,
  input  logic       PIPE_FLUSH,
  input  logic       MEM_REQ,
  input  logic       MEM_ACK,
  output logic       PC_EN,
  output logic       IF_ID_EN,
  output logic       ID_EX_EN,
  output logic       EX_MEM_EN,
  output logic       MEM_WB_EN,
  output logic       IF_ID_CLR,
  output logic       ID_EX_CLR,
  output logic [3:0] VALID,
  output logic [1:0] STATE,
  output logic       MEM_ERR
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] CYC_CNT,
  output logic [15:0] STALL_CNT,
  output logic [15:0] FLUSH_CNT
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    MWAIT = 2'b10,
    ERR   = 2'b11
  } state_t;

  localparam logic [3:0] TIMEOUT_LIMIT = 4'(MEM_TIMEOUT);

  state_t     state_reg;
  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;
  logic [3:0] valid_reg;
  logic       mem_err_reg;
  logic       active;
  logic       mem_wait;

  assign active   = RST_n && ((state_reg == RUN) || (state_reg == MWAIT));
  assign mem_wait = ((state_reg == RUN) && MEM_REQ && !MEM_ACK) ||
                    ((state_reg == MWAIT) && !MEM_ACK);
  assign wait_cnt_next = (wait_cnt_reg == 4'hF) ? 4'hF : wait_cnt_reg + 4'd1;

  // Priority: memory wait freezes everything, then flush, then load-use stall.
  always_comb begin
    PC_EN     = 1'b0;
    IF_ID_EN  = 1'b0;
    ID_EX_EN  = 1'b0;
    EX_MEM_EN = 1'b0;
    MEM_WB_EN = 1'b0;
    IF_ID_CLR = 1'b0;
    ID_EX_CLR = 1'b0;
    if (active && !mem_wait) begin
      ID_EX_EN  = 1'b1;
      EX_MEM_EN = 1'b1;
      MEM_WB_EN = 1'b1;
      if (PIPE_FLUSH) begin
        PC_EN     = 1'b1;
        IF_ID_EN  = 1'b1;
        IF_ID_CLR = 1'b1;
        ID_EX_CLR = 1'b1;
      end else if (HDU_STALL) begin
        ID_EX_CLR = 1'b1;
      end else begin
        PC_EN    = 1'b1;
        IF_ID_EN = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_reg    <= BOOT;
      wait_cnt_reg <= 4'd0;
      valid_reg    <= 4'd0;
      mem_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: state_reg <= RUN;
        RUN: begin
          if (MEM_REQ && !MEM_ACK) begin
            state_reg    <= MWAIT;
            wait_cnt_reg <= 4'd0;
          end
        end
        MWAIT: begin
          if (MEM_ACK) begin
            state_reg <= RUN;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (wait_cnt_next >= TIMEOUT_LIMIT) begin
              state_reg   <= ERR;
              mem_err_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= ERR;
      endcase
      if (MEM_WB_EN) valid_reg[3] <= valid_reg[2];
      if (EX_MEM_EN) valid_reg[2] <= valid_reg[1];
      if (ID_EX_EN)  valid_reg[1] <= ID_EX_CLR ? 1'b0 : valid_reg[0];
      if (IF_ID_EN)  valid_reg[0] <= !IF_ID_CLR;
    end
  end

  assign VALID   = valid_reg;
  assign STATE   = state_reg;
  assign MEM_ERR = mem_err_reg;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_cnt_reg;
  logic [15:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cyc_cnt_reg   <= 32'd0;
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else if (active) begin
      if (cyc_cnt_reg != 32'hFFFF_FFFF) cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
      if ((mem_wait || (!PIPE_FLUSH && HDU_STALL)) && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (!mem_wait && PIPE_FLUSH && (flush_cnt_reg != 16'hFFFF))
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign CYC_CNT   = cyc_cnt_reg;
  assign STALL_CNT = stall_cnt_reg;
  assign FLUSH_CNT = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: cycle-level reference model plus directed literal checks.
module tb_pipe_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0, hdu_stall = 1'b0, pipe_flush = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr, mem_err;
  logic [3:0] valid;
  logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .CLK(clk), .RST_n(rst_n), .HDU_STALL(hdu_stall), .PIPE_FLUSH(pipe_flush),
    .MEM_REQ(mem_req), .MEM_ACK(mem_ack), .PC_EN(pc_en), .IF_ID_EN(if_id_en),
    .ID_EX_EN(id_ex_en), .EX_MEM_EN(ex_mem_en), .MEM_WB_EN(mem_wb_en),
    .IF_ID_CLR(if_id_clr), .ID_EX_CLR(id_ex_clr), .VALID(valid), .STATE(state),
    .MEM_ERR(mem_err)
`ifdef PIPE_CTRL_PERF_EN
    , .CYC_CNT(cyc_cnt), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline as four occupancy bits, controller mode chosen per cycle.
  typedef enum int {M_IDLE, M_MEMWAIT, M_FLUSH, M_STALL, M_NORMAL} mode_t;
  bit       known = 0;
  int       m_state = 0;   // 0 boot, 1 run, 2 mwait, 3 err
  int       m_waited = 0;
  bit       m_err = 0;
  bit [3:0] m_valid = 0;
  longint   m_cyc = 0, m_stl = 0, m_fls = 0;

  function automatic mode_t cur_mode();
    if (!rst_n || m_state == 0 || m_state == 3) return M_IDLE;
    if ((m_state == 1 && mem_req && !mem_ack) || (m_state == 2 && !mem_ack)) return M_MEMWAIT;
    if (pipe_flush) return M_FLUSH;
    if (hdu_stall) return M_STALL;
    return M_NORMAL;
  endfunction

  function automatic logic [6:0] exp_ctl(input mode_t m);
    // {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_CLR, ID_EX_CLR}
    case (m)
      M_FLUSH:  return 7'b1111111;
      M_STALL:  return 7'b0011101;
      M_NORMAL: return 7'b1111100;
      default:  return 7'b0000000;
    endcase
  endfunction

  always @(posedge clk) begin
    mode_t m;
    m = cur_mode();
    if (!rst_n) begin
      known = 1; m_state = 0; m_waited = 0; m_err = 0; m_valid = 0;
      m_cyc = 0; m_stl = 0; m_fls = 0;
    end else if (known) begin
      if (m_state == 1 || m_state == 2) m_cyc++;
      if (m == M_MEMWAIT || m == M_STALL) m_stl++;
      if (m == M_FLUSH) m_fls++;
      case (m)
        M_NORMAL: m_valid = {m_valid[2], m_valid[1], m_valid[0], 1'b1};
        M_FLUSH:  m_valid = {m_valid[2], m_valid[1], 1'b0, 1'b0};
        M_STALL:  m_valid = {m_valid[2], m_valid[1], 1'b0, m_valid[0]};
        default:  ;
      endcase
      case (m_state)
        0: m_state = 1;
        1: if (mem_req && !mem_ack) begin m_state = 2; m_waited = 0; end
        2: if (mem_ack) m_state = 1;
           else begin
             m_waited++;
             if (m_waited == TO) begin m_state = 3; m_err = 1; end
           end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (known) begin
      chk("ctl", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr},
          exp_ctl(cur_mode()));
      chk("valid", valid, m_valid);
      chk("state", state, m_state);
      chk("mem_err", mem_err, m_err);
`ifdef PIPE_CTRL_PERF_EN
      chk("cyc_cnt", cyc_cnt, m_cyc);
      chk("stall_cnt", stall_cnt, m_stl);
      chk("flush_cnt", flush_cnt, m_fls);
`endif
    end
  end

  task automatic step(input bit r, input bit s, input bit f, input bit q, input bit a);
    @(posedge clk);
    #1;
    rst_n = r; hdu_stall = s; pipe_flush = f; mem_req = q; mem_ack = a;
    @(negedge clk);
  endtask

  logic [3:0] pat [16] = '{4'h0, 4'h8, 4'h4, 4'hC, 4'h0, 4'h2, 4'h2, 4'h3,
                           4'hA, 4'h0, 4'h9, 4'h5, 4'h0, 4'h8, 4'h0, 4'h0};

  initial begin
    step(0, 0, 0, 0, 0);
    chk("rst_state", state, 2'b00); chk("rst_valid", valid, 4'b0000);
    chk("rst_err", mem_err, 1'b0);  chk("rst_pc_en", pc_en, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("boot_state", state, 2'b00); chk("boot_pc_en", pc_en, 1'b0);
    step(1, 0, 0, 0, 0);
    chk("run_state", state, 2'b01); chk("valid_0000", valid, 4'b0000);
    step(1, 0, 0, 0, 0); chk("valid_0001", valid, 4'b0001);
    step(1, 0, 0, 0, 0); chk("valid_0011", valid, 4'b0011);
    step(1, 0, 0, 0, 0); chk("valid_0111", valid, 4'b0111);
    step(1, 1, 0, 0, 0);
    chk("valid_1111", valid, 4'b1111); chk("stall_pc_en", pc_en, 1'b0);
    chk("stall_if_id_en", if_id_en, 1'b0); chk("stall_id_ex_clr", id_ex_clr, 1'b1);
    step(1, 0, 0, 0, 0); chk("stall_valid_1101", valid, 4'b1101);
    step(1, 0, 0, 0, 0); chk("valid_1011", valid, 4'b1011);
    step(1, 0, 0, 0, 0); chk("valid_0111b", valid, 4'b0111);
    step(1, 1, 1, 0, 0);
    chk("fs_valid", valid, 4'b1111); chk("fs_if_id_clr", if_id_clr, 1'b1);
    chk("fs_id_ex_clr", id_ex_clr, 1'b1); chk("fs_pc_en", pc_en, 1'b1);
    step(1, 0, 0, 0, 0); chk("flush_valid_1100", valid, 4'b1100);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    // three wait cycles, then acknowledge
    step(1, 0, 0, 1, 0); chk("mw1_pc_en", pc_en, 1'b0); chk("mw1_state", state, 2'b01);
    step(1, 0, 0, 1, 0); chk("mw2_state", state, 2'b10); chk("mw2_valid", valid, 4'b1111);
    chk("mw2_mem_wb_en", mem_wb_en, 1'b0);
    step(1, 0, 0, 1, 0); chk("mw3_state", state, 2'b10);
    step(1, 0, 0, 1, 1); chk("ack_state", state, 2'b10); chk("ack_pc_en", pc_en, 1'b1);
    step(1, 0, 0, 0, 0); chk("resume_state", state, 2'b01); chk("resume_err", mem_err, 1'b0);
    // ack on the last permitted wait cycle
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0); step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1); chk("edge_ack_state", state, 2'b10);
    step(1, 0, 0, 0, 0); chk("edge_state", state, 2'b01); chk("edge_err", mem_err, 1'b0);
    // flush arriving together with ack
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 1); chk("ackfl_if_id_clr", if_id_clr, 1'b1); chk("ackfl_pc_en", pc_en, 1'b1);
    step(1, 0, 0, 0, 0); chk("ackfl_state", state, 2'b01);
    // timeout into ERR, hazards ignored there
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < TO; i++) step(1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    chk("to_state", state, 2'b11); chk("to_err", mem_err, 1'b1);
    chk("err_pc_en", pc_en, 1'b0); chk("err_if_id_clr", if_id_clr, 1'b0);
    step(0, 0, 0, 0, 0); chk("inrst_id_ex_en", id_ex_en, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("rerst_state", state, 2'b00); chk("rerst_err", mem_err, 1'b0); chk("rerst_valid", valid, 4'b0000);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, pat[i][3], pat[i][2], pat[i][1], pat[i][0]);
`ifdef PIPE_CTRL_PERF_EN
    step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("perf_cyc", cyc_cnt, 32'd8); chk("perf_stall", stall_cnt, 16'd2);
    chk("perf_flush", flush_cnt, 16'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max data-memory wait cycles before error (range 1-15).
REQ-002 SHALL have ports:
- CLK  in  1  rising-edge clock
- RST_n  in  1  synchronous active-low reset
- HDU_STALL  in  1  load-use hazard from HDU
- PIPE_FLUSH  in  1  branch mispredict flush from CU
- MEM_REQ  in  1  load/store in MEM stage
- MEM_ACK  in  1  data memory done
- PC_EN  out  1  PC register load
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1 each  stage register enables
- IF_ID_CLR, ID_EX_CLR  out  1 each  insert bubble (NOP) into stage register
- VALID  out  4  valid bit per stage: [0]=ID, [1]=EX, [2]=MEM, [3]=WB
- STATE  out  2  FSM state code
- MEM_ERR  out  1  sticky memory timeout flag
REQ-003 SHALL use one clock CLK; reset RST_n synchronous, active-low.

Function
REQ-004 SHALL implement FSM: BOOT=00, RUN=01, MWAIT=10, ERR=11; STATE drives code directly.
REQ-005 BOOT SHALL last exactly 1 cycle after reset release, all enables 0, clears 0, then go to RUN.
REQ-006 RUN SHALL go to MWAIT when MEM_REQ=1 and MEM_ACK=0; otherwise stays RUN.
REQ-007 MWAIT SHALL return to RUN the cycle after MEM_ACK=1; go to ERR when wait counter reaches MEM_TIMEOUT with MEM_ACK=0.
REQ-008 Wait counter (4 bit) SHALL clear on entry to MWAIT, increment each MWAIT cycle, saturate at 15.
REQ-009 ERR SHALL be terminal until reset: all enables 0, MEM_ERR=1.
REQ-010 Outputs SHALL be combinational from state and inputs, priority mem-wait > flush > stall > normal.
REQ-011 Mem-wait (RUN with MEM_REQ=1 & MEM_ACK=0, or MWAIT with MEM_ACK=0): all enables 0, clears 0, VALID held.
REQ-012 Flush (RUN or MWAIT-with-ACK, PIPE_FLUSH=1): all enables 1, IF_ID_CLR=1, ID_EX_CLR=1.
REQ-013 Stall (HDU_STALL=1, no flush): PC_EN=0, IF_ID_EN=0, ID_EX_CLR=1, ID_EX_EN/EX_MEM_EN/MEM_WB_EN=1.
REQ-014 Normal: all enables 1, clears 0.
REQ-015 Simultaneous PIPE_FLUSH and HDU_STALL SHALL resolve as flush (stalled ID instruction squashed).
REQ-016 VALID SHALL update on CLK per enable: VALID[3]<=VALID[2] if MEM_WB_EN; VALID[2]<=VALID[1] if EX_MEM_EN; VALID[1]<=ID_EX_CLR?0:VALID[0] if ID_EX_EN; VALID[0]<=IF_ID_CLR?0:1 if IF_ID_EN; held otherwise.
REQ-017 HDU_STALL and PIPE_FLUSH SHALL be ignored in BOOT and ERR.

Reset
REQ-018 RST_n=0 at a rising edge SHALL set STATE=BOOT, VALID=0000, MEM_ERR=0, wait counter=0; valid mid-operation including ERR.
REQ-019 During reset all enables and clears SHALL be 0.

Configuration
REQ-020 With PIPE_CTRL_PERF_EN defined, SHALL add outputs CYC_CNT (32), STALL_CNT (16), FLUSH_CNT (16): CYC_CNT counts RUN+MWAIT cycles, STALL_CNT counts stall and mem-wait cycles, FLUSH_CNT counts flush cycles; all saturating, cleared by reset.
REQ-021 Without PIPE_CTRL_PERF_EN, these ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-022 Reset release, no hazards -> STATE 00 for 1 cycle then 01; VALID 0001,0011,0111,1111 on successive cycles.
REQ-023 RUN, VALID=1111, HDU_STALL=1 one cycle -> PC_EN=0, IF_ID_EN=0, ID_EX_CLR=1; next VALID=1101.
REQ-024 VALID=1111, PIPE_FLUSH=1 and HDU_STALL=1 same cycle -> both clears 1, PC_EN=1; next VALID=1100.
REQ-025 MEM_REQ=1, MEM_ACK=0 for 3 cycles then 1 -> enables 0 for 3 cycles, STATE=10, VALID frozen; RUN resumes, no MEM_ERR.
REQ-026 MEM_TIMEOUT=4, MEM_REQ=1, MEM_ACK never -> STATE=11, MEM_ERR=1 after 4 MWAIT cycles; RST_n=0 one edge -> STATE=00, MEM_ERR=0.
REQ-027 PIPE_CTRL_PERF_EN defined, 2 stall + 1 flush + 5 normal cycles after BOOT -> CYC_CNT=8, STALL_CNT=2, FLUSH_CNT=1.
